// File: rtl/mul_div_unit_if.sv
// Bus bundle for the multi-cycle multiply/divide unit: launch/cancel controls,
// HI/LO move-to writes, and status/result outputs.
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        cancel;
  logic        hiWrite;
  logic        loWrite;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, srcA, srcB, cancel, hiWrite, loWrite, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, cancel, hiWrite, loWrite, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// 32-bit MULT/MULTU/DIV/DIVU unit: 32-step shift-add multiply and restoring
// divide on magnitudes, with sign correction and HI/LO writeback at the end.
module mul_div_unit (
  input  logic            clk,
  input  logic            rst,
  mul_div_unit_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        div0_q, div0_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        sgn;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum, div_up, div_diff;
  logic [64:0] div_sh;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    sgn      = ~bus.op[0];
    a_abs    = (sgn && bus.srcA[31]) ? 32'd0 - bus.srcA : bus.srcA;
    b_abs    = (sgn && bus.srcB[31]) ? 32'd0 - bus.srcB : bus.srcB;
    // acc holds {33-bit upper, 32-bit lower}: product accumulates in upper and
    // shifts right; for divide, remainder grows in upper as the dividend shifts left.
    mul_sum  = acc_q[64:32] + {1'b0, opnd_q};
    div_sh   = {acc_q[63:0], 1'b0};
    div_up   = div_sh[64:32];
    div_diff = div_up - {1'b0, opnd_q};
    prod_fix = neg_q ? 64'd0 - acc_q[63:0] : acc_q[63:0];
    quo_fix  = neg_q ? 32'd0 - acc_q[31:0] : acc_q[31:0];
    rem_fix  = rneg_q ? 32'd0 - acc_q[63:32] : acc_q[63:32];

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          is_div_d = bus.op[1];
          opnd_d   = bus.op[1] ? b_abs : a_abs;
          acc_d    = {33'd0, (bus.op[1] ? a_abs : b_abs)};
          neg_d    = sgn && (bus.srcA[31] ^ bus.srcB[31]);
          rneg_d   = sgn && bus.srcA[31];
          div0_d   = (bus.srcB == '0);
        end else if (!bus.start) begin
          if (bus.hiWrite) hi_d = bus.wdata;
          if (bus.loWrite) lo_d = bus.wdata;
        end
      end
      S_CALC: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (div_up >= {1'b0, opnd_q}) acc_d = {div_diff, div_sh[31:1], 1'b1};
            else                          acc_d = div_sh;
          end else begin
            acc_d = acc_q[0] ? {1'b0, mul_sum, acc_q[31:1]}
                             : {1'b0, acc_q[64:32], acc_q[31:1]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide by zero leaves remainder = |dividend|, so sign fix restores srcA.
            lo_d = div0_q ? '1 : quo_fix;
            hi_d = rem_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, corner sequences
// (restart, cancel, MTHI/MTLO, async reset) and random ops vs. an arithmetic model.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  mul_div_unit_if m();
  mul_div_unit dut (.clk(clk), .rst(rst), .bus(m.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          restart_at;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      2'd0: begin q = sa * sb; p = q; end
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Launch one op and follow it to done (bounded); restart_at re-asserts start
  // with junk operands at that edge, and MTHI/MTLO are pulsed while busy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int restart_at, output int lat, output int busy_err);
    lat = -1;
    busy_err = 0;
    @(negedge clk);
    m.start = 1'b1; m.op = op; m.srcA = a; m.srcB = b;
    @(posedge clk); #1;
    if (!m.busy) busy_err++;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      m.start   = (n == restart_at);
      m.op      = op ^ 2'b01;
      m.srcA    = $urandom;
      m.srcB    = $urandom;
      m.hiWrite = (n == 7) || (n == 33);
      m.loWrite = (n == 7) || (n == 33);
      m.wdata   = $urandom;
      @(posedge clk); #1;
      if (m.done) lat = n;
      if (m.busy != (n < 33)) busy_err++;
    end
    m.start = 1'b0; m.hiWrite = 1'b0; m.loWrite = 1'b0;
  endtask

  vec_t vecs[$];
  int   lat, berr, seen, bseen;
  logic [1:0]  rop;
  logic [31:0] ra, rb;
  logic [63:0] exp_r;

  initial begin
    m.start = 0; m.op = 0; m.srcA = 0; m.srcB = 0; m.cancel = 0;
    m.hiWrite = 0; m.loWrite = 0; m.wdata = 0;

    vecs.push_back('{2'd0, 32'hFFFF_FFFF, 32'd3,          0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  0, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2,          0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'd3, 32'd7,         32'd0,          0, 32'h0000_0007, 32'hFFFF_FFFF});
    vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  5, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd0,          0, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
    vecs.push_back('{2'd2, 32'd7,         32'hFFFF_FFFE,  0, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{2'd3, 32'd100,       32'd7,          0, 32'h0000_0002, 32'h0000_000E});
    vecs.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000,  0, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{2'd1, 32'h0001_0000, 32'h0001_0000,  0, 32'h0000_0001, 32'h0000_0000});

    // Async reset, then release mid-cycle so the first start meets the first live edge.
    #1 rst = 1'b0;
    #1;
    check("reset_state", {30'd0, m.busy, m.done, m.hi, m.lo}, 64'd0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].restart_at, lat, berr);
      check($sformatf("vec%0d_result", i), {m.hi, m.lo}, {vecs[i].hi, vecs[i].lo});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      check($sformatf("vec%0d_busy", i), 64'(berr), 64'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), {63'd0, m.done}, 64'd0);
    end

    // cancel + start together in IDLE: start dropped
    @(negedge clk);
    m.start = 1; m.cancel = 1; m.op = 2'd1; m.srcA = 32'd5; m.srcB = 32'd6;
    @(posedge clk); #1;
    check("cancel_start_idle", {63'd0, m.busy}, 64'd0);
    @(negedge clk); m.start = 0; m.cancel = 0;

    // MTHI+MTLO together, then MTHI alone
    m.hiWrite = 1; m.loWrite = 1; m.wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("mthi_mtlo_both", {m.hi, m.lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
    @(negedge clk); m.loWrite = 0; m.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    check("mthi", {m.hi, m.lo}, {32'h1234_5678, 32'hCAFE_F00D});

    // DIVU 100/7 with MTHI alongside start (ignored) and cancel sampled at E10
    @(negedge clk);
    m.hiWrite = 1; m.wdata = 32'hDEAD_BEEF; m.start = 1; m.op = 2'd3; m.srcA = 32'd100; m.srcB = 32'd7;
    @(posedge clk); #1;
    check("cancel_op_busy", {63'd0, m.busy}, 64'd1);
    seen = 0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      m.start = 0; m.hiWrite = 0; m.cancel = (n == 10);
      @(posedge clk); #1;
      if (m.done) seen++;
    end
    check("cancel_busy_low", {63'd0, m.busy}, 64'd0);
    m.cancel = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (m.done) seen++;
    end
    check("cancel_no_done", 64'(seen), 64'd0);
    check("cancel_hilo_kept", {m.hi, m.lo}, {32'h1234_5678, 32'hCAFE_F00D});

    // Async reset during MULTU at E5
    @(negedge clk);
    m.start = 1; m.op = 2'd1; m.srcA = 32'hFFFF_FFFF; m.srcB = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk); m.start = 0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midop_reset", {30'd0, m.busy, m.done, m.hi, m.lo}, 64'd0);
    @(negedge clk); rst = 1'b1;
    seen = 0; bseen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (m.done) seen++;
      if (m.busy) bseen++;
    end
    check("post_reset_quiet", {32'(seen), 32'(bseen)}, 64'd0);

    // Random ops against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      exp_r = model(rop, ra, rb);
      run_op(rop, ra, rb, (i % 5 == 0) ? 3 : 0, lat, berr);
      check($sformatf("rand%0d op%0d %h %h", i, rop, ra, rb), {m.hi, m.lo}, exp_r);
      check($sformatf("rand%0d_timing", i), {32'(lat), 32'(berr)}, {32'd33, 32'd0});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
